display_capture: RTL and testbench

- Receiving end of the multiplexed 4-digit seven-segment bus (an/seg) that the game's display driver produces.
- Samples the bus and filters out transient and ghost patterns.
- Decodes each digit back to BCD and reassembles the timer and score values.
- Used as a loop-back checker on the board and as a scoreboard source in system benches.

---
 rtl/display_pkg.sv | 54 +++++
 rtl/display_capture_if.sv | 17 +
 rtl/display_capture_seg_to_bcd.sv | 43 ++++
 rtl/display_capture.sv | 123 ++++++++++++
 tb/tb_display_capture.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// display_pkg: constants shared by the seven-segment display driver and
// the display_capture receiver.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment patterns {g,f,e,d,c,b,a}
//   AN_TT/AN_TO/AN_ST/AN_SO : active-low anode pattern for each digit slot
//   slot_e                  : digit slot index (timer tens/ones, score tens/ones)
//   an_to_slot()            : maps an anode pattern to a slot, flags non one-hot
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_TT = 4'b1110;
    localparam logic [3:0] AN_TO = 4'b1101;
    localparam logic [3:0] AN_ST = 4'b1011;
    localparam logic [3:0] AN_SO = 4'b0111;

    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SLOT_TT = 2'd0,
        SLOT_TO = 2'd1,
        SLOT_ST = 2'd2,
        SLOT_SO = 2'd3
    } slot_e;

    typedef struct packed {
        logic  valid;
        slot_e slot;
    } slot_dec_t;

    function automatic slot_dec_t an_to_slot(input logic [3:0] an);
        slot_dec_t d;
        d.valid = 1'b1;
        d.slot  = SLOT_TT;
        case (an)
            AN_TT:   d.slot = SLOT_TT;
            AN_TO:   d.slot = SLOT_TO;
            AN_ST:   d.slot = SLOT_ST;
            AN_SO:   d.slot = SLOT_SO;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/display_capture_if.sv
// display_capture_if: multiplexed seven-segment bus plus the reconstructed
// values.
//   an, seg           : digit enables / segments, both active-low
//   timer, score      : reconstructed binary values
//   frame_valid, err  : one-cycle status pulses
// master = the side driving the display bus, slave = display_capture.
interface display_capture_if;
    logic [3:0] an;
    logic [6:0] seg;
    logic [5:0] timer;
    logic [5:0] score;
    logic       frame_valid;
    logic       err;

    modport master (output an, seg, input timer, score, frame_valid, err);
    modport slave  (input an, seg, output timer, score, frame_valid, err);
endinterface

// File: rtl/display_capture_seg_to_bcd.sv
// seg_to_bcd: combinational active-low seven-segment to BCD decoder.
//   i_seg   : segments {g,f,e,d,c,b,a}, active-low
//   i_tens  : digit sits in a tens slot (enables leading-blank decode)
//   o_bcd   : decoded digit, 0 when invalid
//   o_valid : pattern is a legal digit
// Build option CAPTURE_BLANK_EN: all-off on a tens slot decodes as 0.
module seg_to_bcd
    import display_pkg::*;
(
    input  logic [6:0] i_seg,
    input  logic       i_tens,
    output logic [3:0] o_bcd,
    output logic       o_valid
);

`ifndef CAPTURE_BLANK_EN
    logic w_unused_tens;
    assign w_unused_tens = i_tens;
`endif

    always_comb begin
        o_bcd   = 4'd0;
        o_valid = 1'b1;
        case (i_seg)
            SEG_0: o_bcd = 4'd0;
            SEG_1: o_bcd = 4'd1;
            SEG_2: o_bcd = 4'd2;
            SEG_3: o_bcd = 4'd3;
            SEG_4: o_bcd = 4'd4;
            SEG_5: o_bcd = 4'd5;
            SEG_6: o_bcd = 4'd6;
            SEG_7: o_bcd = 4'd7;
            SEG_8: o_bcd = 4'd8;
            SEG_9: o_bcd = 4'd9;
`ifdef CAPTURE_BLANK_EN
            // Leading blank: the driver suppresses a zero tens digit.
            SEG_BLANK: o_valid = i_tens;
`endif
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_capture.sv
// display_capture: receiver for the multiplexed 4-digit seven-segment bus.
// Samples {an,seg}, waits for STABLE_CYCLES identical samples, decodes the
// digit into its slot and, once all four slots are seen, publishes
// timer/score with a frame_valid pulse (or err if a value exceeds 63).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : display_capture_if.slave (an/seg in, timer/score/
//                frame_valid/err out)
// Build option CAPTURE_BLANK_EN: see seg_to_bcd.
module display_capture
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,   // 1..255
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    display_capture_if.slave bus
);

    logic [10:0]                  r_sample;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_cnt_moved;
    logic [NUM_SLOTS-1:0]         r_seen;
    logic [NUM_SLOTS-1:0][3:0]    r_slot;
    logic [5:0]                   r_timer;
    logic [5:0]                   r_score;
    logic                         r_fv;
    logic                         r_err;

    logic [10:0]                  w_in;
    slot_dec_t                    w_dec;
    logic                         w_tens;
    logic [3:0]                   w_bcd;
    logic                         w_dig_ok;
    logic                         w_accept;
    logic [NUM_SLOTS-1:0]         w_seen_nxt;
    logic [NUM_SLOTS-1:0][3:0]    w_dig;
    logic [6:0]                   w_tsum;
    logic [6:0]                   w_ssum;
    logic                         w_in_range;

    assign w_in  = {bus.an, bus.seg};
    assign w_dec = an_to_slot(r_sample[10:7]);
    assign w_tens = (w_dec.slot == SLOT_TT) || (w_dec.slot == SLOT_ST);

    // r_cnt_moved guards against repeated accepts once the counter has
    // saturated at a value equal to STABLE_CYCLES.
    assign w_accept = r_cnt_moved && (r_cnt == CNT_W'(STABLE_CYCLES)) && w_dec.valid;

    seg_to_bcd u_dec (
        .i_seg   (r_sample[6:0]),
        .i_tens  (w_tens),
        .o_bcd   (w_bcd),
        .o_valid (w_dig_ok)
    );

    // Slot contents as they will be after this accept, so the completing
    // digit takes part in the sums in the same cycle.
    always_comb begin
        w_dig = r_slot;
        if (w_accept)
            w_dig[w_dec.slot] = w_bcd;
    end

    assign w_seen_nxt = r_seen | (NUM_SLOTS'(1) << w_dec.slot);
    assign w_tsum     = 7'(w_dig[SLOT_TT]) * 7'd10 + 7'(w_dig[SLOT_TO]);
    assign w_ssum     = 7'(w_dig[SLOT_ST]) * 7'd10 + 7'(w_dig[SLOT_SO]);
    assign w_in_range = (w_tsum <= 7'd63) && (w_ssum <= 7'd63);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample    <= '0;
            r_cnt       <= '0;
            r_cnt_moved <= 1'b0;
            r_seen      <= '0;
            r_slot      <= '0;
            r_timer     <= '0;
            r_score     <= '0;
            r_fv        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sample <= w_in;
            if (w_in != r_sample) begin
                r_cnt       <= CNT_W'(1);
                r_cnt_moved <= 1'b1;
            end else if (r_cnt != '1) begin
                r_cnt       <= r_cnt + CNT_W'(1);
                r_cnt_moved <= 1'b1;
            end else begin
                r_cnt_moved <= 1'b0;
            end

            r_fv  <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                if (w_dig_ok) begin
                    r_slot[w_dec.slot] <= w_bcd;
                    if (&w_seen_nxt) begin
                        r_seen <= '0;
                        if (w_in_range) begin
                            r_timer <= w_tsum[5:0];
                            r_score <= w_ssum[5:0];
                            r_fv    <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_seen <= w_seen_nxt;
                    end
                end else begin
                    r_err  <= 1'b1;
                    r_seen <= '0;
                end
            end
        end
    end

    assign bus.timer       = r_timer;
    assign bus.score       = r_score;
    assign bus.frame_valid = r_fv;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: a table of whole frames applied to a
// STABLE_CYCLES=2 and a STABLE_CYCLES=3 instance in parallel, followed by
// hand-written latency, reset and ghost-filter sequences.
module tb_display_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an_d;
    logic [6:0] seg_d;

    always #5 clk = ~clk;

    display_capture_if bus2 ();
    display_capture_if bus3 ();
    assign bus2.an = an_d;
    assign bus2.seg = seg_d;
    assign bus3.an = an_d;
    assign bus3.seg = seg_d;

    display_capture #(.STABLE_CYCLES(2), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    display_capture #(.STABLE_CYCLES(3), .CNT_W(8)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int checks = 0;
    int errors = 0;
    int fv2_cnt = 0, err2_cnt = 0, fv3_cnt = 0, err3_cnt = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1010101;
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct {
        logic [3:0][6:0] sg;   // index 0 = timer tens .. 3 = score ones
        int              ndig;
        int              exp_fv;
        int              exp_err;
        int              exp_t;
        int              exp_s;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [3:0][6:0] mk(input logic [6:0] tt, input logic [6:0] to,
                                           input logic [6:0] st, input logic [6:0] so);
        return {so, st, to, tt};
    endfunction

    function automatic vec_t mkv(input logic [3:0][6:0] sg, input int nd, input int fv,
                                 input int er, input int t, input int s);
        vec_t v;
        v.sg = sg; v.ndig = nd; v.exp_fv = fv; v.exp_err = er; v.exp_t = t; v.exp_s = s;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic put(input logic [3:0] a, input logic [6:0] s, input int n);
        an_d  = a;
        seg_d = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [3:0][6:0] sg, input int nd, input int hold, input int gap);
        for (int i = 0; i < nd; i++) begin
            put(an_tab[i], sg[i], hold);
            if (gap > 0) put(4'b1111, BLANK, gap);
        end
        put(4'b1111, BLANK, 4);
    endtask

    task automatic clr();
        fv2_cnt = 0; err2_cnt = 0; fv3_cnt = 0; err3_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (bus2.frame_valid) fv2_cnt++;
        if (bus2.err)         err2_cnt++;
        if (bus3.frame_valid) fv3_cnt++;
        if (bus3.err)         err3_cnt++;
        if ((bus2.frame_valid && bus2.err) || (bus3.frame_valid && bus3.err)) begin
            checks++;
            errors++;
            $display("FAIL fv_err_exclusive: frame_valid and err both 1");
        end
    end

    initial begin
        vecs[0] = mkv(mk(enc(4), enc(2), enc(1), enc(7)), 4, 1, 0, 42, 17);
        vecs[1] = mkv(mk(enc(0), BAD,    enc(0), enc(0)), 2, 0, 1, 42, 17);
        vecs[2] = mkv(mk(enc(0), enc(5), enc(0), enc(9)), 4, 1, 0, 5, 9);
        vecs[3] = mkv(mk(enc(7), enc(0), enc(0), enc(9)), 4, 0, 1, 5, 9);
        vecs[4] = mkv(mk(enc(6), enc(3), enc(6), enc(3)), 4, 1, 0, 63, 63);
        vecs[5] = mkv(mk(enc(6), enc(4), enc(0), enc(0)), 4, 0, 1, 63, 63);
        vecs[6] = mkv(mk(enc(9), enc(9), enc(9), enc(9)), 4, 0, 1, 63, 63);
        vecs[7] = mkv(mk(enc(0), enc(0), enc(0), enc(0)), 4, 1, 0, 0, 0);
        vecs[8] = mkv(mk(enc(1), enc(2), enc(3), BLANK),  4, 0, 1, 0, 0);
`ifdef CAPTURE_BLANK_EN
        vecs[9] = mkv(mk(BLANK, enc(8), enc(0), enc(0)),  4, 1, 0, 8, 0);
`else
        vecs[9] = mkv(mk(BLANK, enc(8), enc(0), enc(0)),  4, 0, 1, 0, 0);
`endif

        reset = 1'b1;
        an_d  = 4'b1111;
        seg_d = BLANK;
        repeat (2) @(negedge clk);
        chk("rst_timer2", int'(bus2.timer), 0);
        chk("rst_score2", int'(bus2.score), 0);
        chk("rst_fv2", int'(bus2.frame_valid), 0);
        chk("rst_err2", int'(bus2.err), 0);
        chk("rst_timer3", int'(bus3.timer), 0);
        chk("rst_score3", int'(bus3.score), 0);
        reset = 1'b0;
        put(4'b1111, BLANK, 2);

        for (int v = 0; v < 10; v++) begin
            clr();
            frame(vecs[v].sg, vecs[v].ndig, 4, 0);
            chk($sformatf("vec%0d_fv2", v), fv2_cnt, vecs[v].exp_fv);
            chk($sformatf("vec%0d_err2", v), err2_cnt, vecs[v].exp_err);
            chk($sformatf("vec%0d_timer2", v), int'(bus2.timer), vecs[v].exp_t);
            chk($sformatf("vec%0d_score2", v), int'(bus2.score), vecs[v].exp_s);
            chk($sformatf("vec%0d_fv3", v), fv3_cnt, vecs[v].exp_fv);
            chk($sformatf("vec%0d_err3", v), err3_cnt, vecs[v].exp_err);
            chk($sformatf("vec%0d_timer3", v), int'(bus3.timer), vecs[v].exp_t);
            chk($sformatf("vec%0d_score3", v), int'(bus3.score), vecs[v].exp_s);
        end

        // Clean start for the sequences below.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        put(4'b1111, BLANK, 2);

        // Latency: frame_valid 3 clk (STABLE=2) / 4 clk (STABLE=3) after the
        // last digit appears on the bus.
        clr();
        put(an_tab[0], enc(4), 4);
        put(an_tab[1], enc(2), 4);
        put(an_tab[2], enc(1), 4);
        put(an_tab[3], enc(7), 1);
        chk("lat_n1_fv2", int'(bus2.frame_valid), 0);
        @(negedge clk);
        chk("lat_n2_fv2", int'(bus2.frame_valid), 0);
        @(negedge clk);
        chk("lat_n3_fv2", int'(bus2.frame_valid), 1);
        chk("lat_n3_timer2", int'(bus2.timer), 42);
        chk("lat_n3_fv3", int'(bus3.frame_valid), 0);
        @(negedge clk);
        chk("lat_n4_fv2", int'(bus2.frame_valid), 0);
        chk("lat_n4_fv3", int'(bus3.frame_valid), 1);
        chk("lat_n4_score3", int'(bus3.score), 17);
        put(4'b1111, BLANK, 4);
        chk("lat_fv2_count", fv2_cnt, 1);

        // Reset mid-frame after two accepted digits.
        put(an_tab[0], enc(3), 4);
        put(an_tab[1], enc(0), 4);
        reset = 1'b1;
        #1;
        chk("midrst_timer2", int'(bus2.timer), 0);
        chk("midrst_score2", int'(bus2.score), 0);
        chk("midrst_timer3", int'(bus3.timer), 0);
        an_d  = 4'b1111;
        seg_d = BLANK;
        @(negedge clk);
        reset = 1'b0;
        put(4'b1111, BLANK, 2);
        clr();
        frame(mk(enc(3), enc(0), enc(0), enc(0)), 4, 4, 0);
        chk("midrst_fv2", fv2_cnt, 1);
        chk("midrst_err2", err2_cnt, 0);
        chk("midrst_t2", int'(bus2.timer), 30);
        chk("midrst_s2", int'(bus2.score), 0);
        chk("midrst_fv3", fv3_cnt, 1);

        // Ghost filter: 2-cycle holds pass STABLE=2 but not STABLE=3.
        clr();
        frame(mk(enc(1), enc(2), enc(3), enc(4)), 4, 2, 2);
        chk("ghost2_fv2", fv2_cnt, 1);
        chk("ghost2_t2", int'(bus2.timer), 12);
        chk("ghost2_s2", int'(bus2.score), 34);
        chk("ghost2_fv3", fv3_cnt, 0);
        chk("ghost2_err3", err3_cnt, 0);
        chk("ghost2_t3", int'(bus3.timer), 30);

        clr();
        frame(mk(enc(5), enc(6), enc(2), enc(1)), 4, 3, 1);
        chk("ghost3_fv3", fv3_cnt, 1);
        chk("ghost3_t3", int'(bus3.timer), 56);
        chk("ghost3_s3", int'(bus3.score), 21);
        chk("ghost3_fv2", fv2_cnt, 1);
        chk("ghost3_t2", int'(bus2.timer), 56);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
